// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state codes and size decode for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t S_IDLE   = 3'd0;
  localparam lsu_state_t S_RD_LO  = 3'd1;
  localparam lsu_state_t S_RD_HI  = 3'd2;
  localparam lsu_state_t S_RD_CAP = 3'd3;
  localparam lsu_state_t S_ST     = 3'd4;
  localparam lsu_state_t S_RESP   = 3'd5;

  // Access size in bytes; the unsigned variants share the low two bits.
  function automatic logic [2:0] lsu_size(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   lsu_size = 3'd1;
      2'b01:   lsu_size = 3'd2;
      default: lsu_size = 3'd4;
    endcase
  endfunction

  function automatic logic lsu_func3_illegal(input logic write, input logic [2:0] func3);
    if (write)
      lsu_func3_illegal = (func3 > F3_W);
    else
      lsu_func3_illegal = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_align.sv
// rtl/lsu_mem_port_load_align.sv - extract and extend load data from a two-word window
// window : {hi_word, lo_word} as read from memory
// offset : byte offset of the load inside lo_word
// func3  : RV32I load funct3
// result : sign/zero extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = window[{offset, 3'b000} +: 32];

  always_comb begin
    case (func3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit driving a word-read, word/byte-write data memory
// clock, reset         : rising-edge clock, asynchronous active-high reset
// req_*                : one load/store request per valid/ready handshake
// resp_*               : extended load data or fault, held until resp_ready
// mem_*                : registered memory port; mem_data_out arrives one cycle after the address
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_func3,
  output logic        mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

  lsu_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic [2:0]  size_q;
  logic        cross_q;
  logic        word_st_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] lo_q;

  logic [2:0]  size_in;
  logic [32:0] last_byte;
  logic        fault_in;
  logic        cross_in;
  logic        aligned_sw_in;
  logic        accept;
  logic        st_done;
  logic [1:0]  byte_idx_next;
  logic [7:0]  next_byte;
  logic [63:0] window;
  logic [31:0] load_result;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;

  assign size_in       = lsu_size(req_func3);
  // 33-bit sum so an access near 2^32 cannot wrap back into range.
  assign last_byte     = {1'b0, req_addr} + {30'b0, size_in} - 33'd1;
  assign fault_in      = lsu_func3_illegal(req_write, req_func3) || (last_byte >= MEM_LIMIT);
  assign cross_in      = ({1'b0, req_addr[1:0]} + size_in) > 3'd4;
  assign aligned_sw_in = (req_func3 == F3_W) && (req_addr[1:0] == 2'b00);

  assign st_done       = word_st_q || ({1'b0, byte_idx_q} == (size_q - 3'd1));
  assign byte_idx_next = byte_idx_q + 2'd1;
  assign next_byte     = wdata_q[{byte_idx_next, 3'b000} +: 8];

  // Non-crossing loads only need the single word now on mem_data_out.
  assign window = cross_q ? {mem_data_out, lo_q} : {32'b0, mem_data_out};

  lsu_load_align u_align (
    .window (window),
    .offset (addr_q[1:0]),
    .func3  (func3_q),
    .result (load_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      func3_q      <= 3'b0;
      size_q       <= 3'd1;
      cross_q      <= 1'b0;
      word_st_q    <= 1'b0;
      byte_idx_q   <= 2'b0;
      lo_q         <= 32'b0;
      resp_rdata   <= 32'b0;
      resp_fault   <= 1'b0;
      mem_address  <= 32'b0;
      mem_func3    <= F3_W;
      mem_write_en <= 1'b0;
      mem_data_in  <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            func3_q    <= req_func3;
            size_q     <= size_in;
            cross_q    <= cross_in;
            word_st_q  <= aligned_sw_in;
            byte_idx_q <= 2'b0;
            resp_rdata <= 32'b0;
            if (fault_in) begin
              resp_fault <= 1'b1;
              state      <= S_RESP;
            end else if (req_write) begin
              resp_fault   <= 1'b0;
              mem_address  <= req_addr;
              mem_write_en <= 1'b1;
              if (aligned_sw_in) begin
                mem_func3   <= F3_W;
                mem_data_in <= req_wdata;
              end else begin
                mem_func3   <= F3_B;
                mem_data_in <= {24'b0, req_wdata[7:0]};
              end
              state <= S_ST;
            end else begin
              resp_fault  <= 1'b0;
              mem_address <= {req_addr[31:2], 2'b00};
              mem_func3   <= F3_W;
              state       <= S_RD_LO;
            end
          end
        end
        S_RD_LO: begin
          if (cross_q) begin
            mem_address <= mem_address + 32'd4;
            state       <= S_RD_HI;
          end else begin
            state <= S_RD_CAP;
          end
        end
        S_RD_HI: begin
          lo_q  <= mem_data_out;
          state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          resp_rdata <= load_result;
          state      <= S_RESP;
        end
        S_ST: begin
          if (st_done) begin
            mem_write_en <= 1'b0;
            mem_func3    <= F3_W;
            state        <= S_RESP;
          end else begin
            byte_idx_q  <= byte_idx_next;
            mem_address <= addr_q + {30'b0, byte_idx_next};
            mem_data_in <= {24'b0, next_byte};
          end
        end
        S_RESP: begin
          if (resp_ready)
            state <= S_IDLE;
        end
        default: begin
          mem_write_en <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the byte-lane data memory in the RISC-V core.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts each request into a sequence of memory-port accesses:
  - loads: aligned word reads only;
  - stores: aligned word writes or single-byte writes.
- Handles misaligned and boundary-crossing accesses and performs all sign/zero extension locally, then returns a response over a valid/ready handshake.

Parameters:
- MEM_SIZE, 1024, data memory size in bytes; must be a power of two ≥ 8.

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request
- req_write  input  1  1 = store, 0 = load
- req_func3  input  3  RV32I funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bytes used for SB/SH)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_fault  output  1  access rejected
- mem_address  output  32  to memory address
- mem_func3  output  3  to memory func3; only 2 (word) or 0 (byte) driven
- mem_write_en  output  1  to memory write enable
- mem_data_in  output  32  to memory write data
- mem_data_out  input  32  from memory; registered, valid the cycle after the address is presented

Behaviour:
- Reset values:
  - state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_write_en=0, mem_address=0, mem_func3=2, mem_data_in=0.
- States: IDLE, RD_LO, RD_HI, RD_CAP, ST, RESP.
- IDLE:
  - req_ready=1; a request is accepted on the edge where req_valid && req_ready.
  - All request fields are latched; size = 1/2/4 bytes from func3[1:0].
- Fault check at acceptance. A fault is raised if any of:
  - illegal func3: 3, 6 or 7 on a load; anything other than 0/1/2 on a store;
  - req_addr + size − 1 ≥ MEM_SIZE (no wrap-around).
  - On fault: go to RESP with resp_fault=1 and resp_rdata=0; no memory access is issued.
- Loads:
  - RD_LO drives mem_address = {addr[31:2],2'b00}, func3=2.
  - If addr[1:0] + size > 4 (crossing), RD_HI drives the next word address and captures the low word from mem_data_out.
  - RD_CAP captures the final word.
  - A 64-bit window {hi,lo} is shifted right by 8·addr[1:0].
  - Result is sign-extended for LB/LH and zero-extended for LBU/LHU/LW, then registered into resp_rdata on entering RESP.
  - Latency, acceptance edge to resp_valid: 2 cycles if not crossing, 3 cycles if crossing.
- Stores:
  - Aligned SW: a single ST cycle with func3=2 and mem_data_in=wdata.
  - Every other store (SB; SH at any offset; misaligned SW) issues `size` consecutive byte writes.
    - Write k uses address addr+k, func3=0, mem_data_in = {24'b0, wdata[8k+7:8k]}.
  - Halfword writes (func3=1) are never issued to memory.
  - mem_write_en=1 only in ST.
  - Latency: resp_valid asserts `size` cycles after acceptance (1 for SW aligned).
- RESP:
  - resp_valid held with stable rdata/fault until resp_ready.
  - On the handshake edge, return to IDLE; the next request is accepted no earlier than the following cycle.
  - req_ready=0 in every state except IDLE.
- Memory outputs are driven from registered state only (no combinational path from req_* to mem_*).
- mem_write_en is never high outside ST.
- Reset mid-operation:
  - immediate return to IDLE with mem_write_en=0;
  - byte stores already written are not rolled back;
  - no response is produced for the aborted request.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - the size-decode function.
- One natural combinational sub-module: lsu_load_align.
  - Inputs: 64-bit window, 2-bit offset, func3.
  - Output: extended 32-bit result.
  - Unit-testable on its own.

Test Plan:
- Aligned SW 0xDEADBEEF @0x10, then LW @0x10 → one write cycle with func3=2; load resp_rdata=0xDEADBEEF 2 cycles after accept, fault=0.
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
- Crossing: SW 0x11223344 @0x20 and SW 0x55667788 @0x24, then LW @0x22 → reads 0x20 then 0x24, rdata=0x77881122, 3-cycle latency. Then LH @0x23 → 0xFFFF8811.
- Misaligned SH 0xA5C3 @0x2F → exactly two byte writes (0x2F=0xC3, 0x30=0xA5); LHU @0x2F → 0x0000A5C3.
- Faults: LW @MEM_SIZE−2 → fault=1, rdata=0, no memory access. Load func3=3 → fault. Store func3=4 → fault.
- Handshake/reset:
  - resp_ready held low 5 cycles → resp_valid and data stable, req_ready=0.
  - reset asserted during the 2nd byte of a misaligned SW → mem_write_en drops immediately; state is IDLE with req_ready=1 after release.
